// File: rtl/adder_pkg.sv
// Shared definitions for the adder responder: FSM states, default width,
// and the register-file depth derived from the width.
package adder_pkg;

  localparam int ADDER_N = 4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ADD,
    DONE
  } state_t;

  // Number of register-file entries for an n-bit address.
  function automatic int adder_depth(input int n);
    return 1 << n;
  endfunction

  localparam int ADDER_DEPTH = adder_depth(ADDER_N);

endpackage

// File: rtl/adder_serial_slice.sv
// One-bit full adder with a registered carry, used as the bit-serial
// datapath of the responder. The carry is cleared before each new sum and
// only advances while enable is high.
module adder_serial_slice (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic a,
  input  logic b,
  output logic sum
);

  logic carry;

  assign sum = a ^ b ^ carry;

  // Carry flop: cleared on reset or clear, otherwise takes the majority of
  // the current operand bits and the previous carry while enabled.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      carry <= 1'b0;
    end else if (enable) begin
      carry <= (a & b) | (a & carry) | (b & carry);
    end
  end

endmodule

// File: rtl/adder_responder.sv
// Responder side of the adder register interface. Holds a 2^N-entry operand
// register file; writes complete in one cycle, adds sum two adjacent entries
// LSB first through a bit-serial slice and return the result with an ack.
module adder_responder
  import adder_pkg::*;
#(
  parameter int N = ADDER_N
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_addr,
  input  logic [N-1:0] i_data,
  input  logic         i_we,
  input  logic         i_start,
  output logic [N-1:0] o_data,
  output logic         o_ready,
  output logic         o_ack
);

  localparam int DEPTH = adder_depth(N);
  localparam int CW    = $clog2(N) + 1;

  logic [N-1:0]  regs [DEPTH];
  state_t        state;
  logic [N-1:0]  op_addr;
  logic [N-1:0]  next_addr;
  logic [N-1:0]  a_sr;
  logic [N-1:0]  b_sr;
  logic [N-1:0]  sum_sr;
  logic [N-1:0]  sum_final;
  logic [CW-1:0] count;
  logic          sum_bit;
  logic          slice_clear;
  logic          slice_enable;

  // Operand B is the entry after A; the N-bit add wraps the top entry to 0.
  assign next_addr    = op_addr + N'(1);
  assign slice_clear  = (state == FETCH);
  assign slice_enable = (state == ADD);
  assign sum_final    = {sum_bit, sum_sr[N-1:1]};

  adder_serial_slice u_slice (
    .clk    (i_clk),
    .rst    (i_rst),
    .clear  (slice_clear),
    .enable (slice_enable),
    .a      (a_sr[0]),
    .b      (b_sr[0]),
    .sum    (sum_bit)
  );

  // Command FSM, register file, operand/sum shift registers and outputs.
  // The result and ack are registered on the last ADD edge so they are
  // visible during the DONE cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      op_addr <= '0;
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      count   <= '0;
      o_data  <= '0;
      o_ready <= 1'b1;
      o_ack   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      o_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start && o_ready) begin
            if (i_we) begin
              regs[i_addr] <= i_data;
              o_ack        <= 1'b1;
            end else begin
              op_addr <= i_addr;
              o_ready <= 1'b0;
              state   <= FETCH;
            end
          end
        end
        FETCH: begin
          a_sr  <= regs[op_addr];
          b_sr  <= regs[next_addr];
          count <= '0;
          state <= ADD;
        end
        ADD: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_final;
          count  <= count + CW'(1);
          if (count == CW'(N - 1)) begin
            o_data <= sum_final;
            o_ack  <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          o_ready <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          o_ready <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_responder.sv
// Directed and randomized checks of adder_responder against a register-array
// model that computes sums with plain modular arithmetic.
module tb_adder_responder;

  localparam int N     = 4;
  localparam int DEPTH = 16;

  logic         i_clk;
  logic         i_rst;
  logic [N-1:0] i_addr;
  logic [N-1:0] i_data;
  logic         i_we;
  logic         i_start;
  logic [N-1:0] o_data;
  logic         o_ready;
  logic         o_ack;

  int model_reg [DEPTH];
  int compared;
  int mismatched;

  adder_responder #(.N(N)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_addr  (i_addr),
    .i_data  (i_data),
    .i_we    (i_we),
    .i_start (i_start),
    .o_data  (o_data),
    .o_ready (o_ready),
    .o_ack   (o_ack)
  );

  // Free-running clock.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one command for a single cycle and updates the model on a write.
  task automatic applyStimulus(input logic we, input int addr, input int data);
    i_start = 1'b1;
    i_we    = we;
    i_addr  = N'(addr);
    i_data  = N'(data);
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_we    = 1'b0;
    if (we) model_reg[addr] = data;
  endtask

  task automatic writeReg(input int addr, input int data);
    applyStimulus(1'b1, addr, data);
    checkOutput("write_ack", o_ack, 1);
    checkOutput("write_ready", o_ready, 1);
  endtask

  // Issues an add and checks latency, result, single ack and return to idle.
  task automatic addCheck(input int addr);
    int expected;
    int k;
    expected = (model_reg[addr] + model_reg[(addr + 1) % DEPTH]) % DEPTH;
    applyStimulus(1'b0, addr, 0);
    k = 1;
    checkOutput("add_busy", o_ready, 0);
    while (o_ack !== 1'b1 && k < 20) begin
      @(posedge i_clk);
      #1;
      k++;
    end
    checkOutput("add_latency", k, 6);
    checkOutput("add_result", o_data, expected);
    @(posedge i_clk);
    #1;
    checkOutput("add_ready_after", o_ready, 1);
    checkOutput("add_ack_single", o_ack, 0);
    checkOutput("add_hold", o_data, expected);
  endtask

  // Main sequence of directed and randomized steps.
  initial begin
    int acks;
    int k;
    compared   = 0;
    mismatched = 0;
    for (int i = 0; i < DEPTH; i++) model_reg[i] = 0;
    i_rst   = 1'b1;
    i_start = 1'b0;
    i_we    = 1'b0;
    i_addr  = '0;
    i_data  = '0;
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("reset_ready", o_ready, 1);
    checkOutput("reset_ack", o_ack, 0);
    checkOutput("reset_data", o_data, 0);
    i_rst = 1'b0;
    addCheck(0);

    writeReg(3, 5);
    writeReg(4, 9);
    addCheck(3);

    writeReg(7, 9);
    writeReg(8, 9);
    addCheck(7);
    writeReg(15, 7);
    writeReg(0, 1);
    addCheck(15);

    // Four writes on consecutive cycles with start held high.
    i_start = 1'b1;
    i_we    = 1'b1;
    for (int j = 0; j < 4; j++) begin
      i_addr = N'(j + 9);
      i_data = N'(j + 1);
      @(posedge i_clk);
      #1;
      model_reg[j + 9] = j + 1;
      checkOutput("b2b_ack", o_ack, 1);
      checkOutput("b2b_ready", o_ready, 1);
    end
    i_start = 1'b0;
    i_we    = 1'b0;
    @(posedge i_clk);
    #1;
    checkOutput("b2b_ack_end", o_ack, 0);
    addCheck(9);

    // A write attempted while an add is in progress must be ignored.
    applyStimulus(1'b0, 10, 0);
    acks = 0;
    @(posedge i_clk);
    #1;
    i_start = 1'b1;
    i_we    = 1'b1;
    i_addr  = 4'd3;
    i_data  = 4'd0;
    for (k = 2; k < 10; k++) begin
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      i_we    = 1'b0;
      if (o_ack === 1'b1) acks++;
    end
    checkOutput("busy_acks", acks, 1);
    checkOutput("busy_result", o_data, (model_reg[10] + model_reg[11]) % DEPTH);
    addCheck(3);

    // Reset asserted in the third ADD cycle aborts the add.
    applyStimulus(1'b0, 3, 0);
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_reg[i] = 0;
    checkOutput("midrst_ack", o_ack, 0);
    checkOutput("midrst_data", o_data, 0);
    checkOutput("midrst_ready", o_ready, 1);
    @(posedge i_clk);
    #1;
    checkOutput("midrst_no_late_ack", o_ack, 0);
    writeReg(5, 6);
    writeReg(6, 7);
    addCheck(5);

    // Randomized operand pairs, including the wrapping top address.
    for (int r = 0; r < 15; r++) begin
      int a;
      a = int'($urandom_range(0, DEPTH - 1));
      writeReg(a, int'($urandom_range(0, DEPTH - 1)));
      writeReg((a + 1) % DEPTH, int'($urandom_range(0, DEPTH - 1)));
      if ($urandom_range(0, 1) == 1) writeReg(int'($urandom_range(0, DEPTH - 1)),
                                              int'($urandom_range(0, DEPTH - 1)));
      addCheck(a);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/adder_responder.md
# adder_responder

Synthesizable responder for the adder register interface: the DUT-side end that the driver modport talks to. It holds a 2^N-entry operand register file written by the initiator. On an add command it sums two adjacent entries with a bit-serial adder, then returns the result with a one-cycle acknowledge. It is the reference DUT that the training benches drive and monitor through the adder interface.

## Interface
- N, 4, address and data width; the register file has 2^N entries of N bits.
- i_clk  input  1  clock; all logic is on the rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_addr  input  N  register address (write target, or operand A index for an add).
- i_data  input  N  write data; ignored for an add.
- i_we  input  1  qualifies i_start: 1 = write, 0 = add.
- i_start  input  1  command strobe; sampled only when o_ready=1.
- o_data  output  N  last add result; held until the next add completes.
- o_ready  output  1  high when idle and able to accept a command.
- o_ack  output  1  one-cycle completion pulse for a write or an add.

## Operation
- Reset (i_rst=1 at an edge): all registers are set to 0, and the state goes to IDLE.
  - Output values after reset: o_data=0, o_ack=0, o_ready=1.
- Command acceptance: a command is accepted only when i_start=1 and o_ready=1.
  - i_start while o_ready=0 is ignored entirely: no state change, no ack, no register write.
- Write (i_we=1): reg[i_addr] <= i_data at the accepting edge.
  - o_ack=1 in the next cycle.
  - o_ready stays 1, so a new command can be accepted in the ack cycle.
  - o_data is unchanged.
- Add (i_we=0): A = reg[i_addr], B = reg[(i_addr+1) mod 2^N]. Address 2^N-1 wraps to entry 0.
  - Result is (A + B) mod 2^N; the final carry is discarded.
- State machine:
  - IDLE: o_ready=1. An accepted add latches i_addr and goes to FETCH. A write stays in IDLE.
  - FETCH: loads A and B into shift registers, clears carry and the bit counter. Goes to ADD.
  - ADD: one bit per cycle, LSB first: sum bit = a^b^c, carry = majority(a,b,c). The counter increments each cycle. After bit N-1, goes to DONE.
  - DONE: loads o_data from the sum shift register, pulses o_ack=1, returns to IDLE.
- o_ready is 0 in FETCH, ADD and DONE.
- The register file is read only in FETCH. Writes cannot occur while busy, so operands are stable.

## Timing
- Write accepted at edge t: o_ack=1 during cycle t+1, deasserted at t+2 unless another write is accepted at t+1.
- Add accepted at edge t:
  - FETCH in cycle t+1.
  - ADD in cycles t+2 .. t+N+1.
  - DONE in cycle t+N+2: o_ack=1 and the new o_data is visible in that cycle.
  - o_ready=1 again in cycle t+N+3.
  - Add latency is N+2 cycles from acceptance to ack (6 for N=4).
- o_ack is never high for more than one cycle per command.
- Reset in the middle of an add aborts it: no o_ack, o_data=0, o_ready=1 on the next cycle.
- i_rst has priority over i_start on the same edge.

## Structure
- Shared package adder_pkg holds:
  - the FSM state enum (IDLE, FETCH, ADD, DONE);
  - the default width constant ADDER_N=4;
  - the derived depth function/constant.
- Sub-module adder_serial_slice: a one-bit full adder with a carry flop. It has clear and enable inputs, so the bit-serial datapath can be checked in isolation.
- Everything else (register file, FSM, shift registers, counter sized $clog2(N)+1) lives in the top.

## Test plan
- Reset: hold i_rst for 2 cycles. Required: o_ready=1, o_ack=0, o_data=0. An add at addr 0 then returns 0.
- Write and add: write reg3=5, reg4=9, then add at addr 3. Required: o_ack exactly 6 cycles after acceptance, o_data=14, o_ready=1 on the following cycle.
- Overflow and address wrap:
  - reg7=9, reg8=9, add at 7: required o_data=2.
  - reg15=7, reg0=1, add at 15: required o_data=8.
- Busy rejection: start an add, then assert i_start with i_we=1, addr 3, data 0 during ADD. Required: ignored, reg3 unchanged, exactly one ack.
- Back-to-back writes: writes on 4 consecutive cycles. Required: 4 consecutive o_ack pulses, o_ready continuously 1.
- Reset mid-add: assert i_rst in the third ADD cycle. Required: no ack, o_data=0, o_ready=1. A subsequent add of a newly written pair returns the correct sum.
